// File: rtl/button_pulse_array.sv
// N-channel push-button shaper: 2-flop sync, debounce, one-cycle press pulse plus debounced level.
// Optional feature macro BTN_REPEAT_EN adds hold-to-auto-repeat pulses on a held button.
module button_pulse_array #(
    parameter int N_BTN     = 4,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5,
    parameter int HOLD_CYC  = 1000,
    parameter int RPT_CYC   = 250,
    parameter int RPT_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] b_in,
    output logic [N_BTN-1:0] b_pulse,
    output logic [N_BTN-1:0] b_level,
    output logic             b_any
);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_HELD} state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    localparam bit CFG_OK = (N_BTN >= 1) && (DB_CYCLES >= 1) &&
                            (DB_CYCLES <= (2 ** CNT_W) - 1) &&
                            (HOLD_CYC >= 1) && (RPT_CYC >= 2) &&
                            (HOLD_CYC <= (2 ** RPT_W)) && (RPT_CYC <= (2 ** RPT_W));

    if (!CFG_OK) begin : g_bad_cfg
        $error("button_pulse_array: illegal parameter combination");
    end

    logic [N_BTN-1:0] r_meta;
    logic [N_BTN-1:0] r_sync;

    // NOTE: the synchroniser resets to "released" (1), not 0, so a button held
    // through reset is seen as a fresh press once reset lifts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= b_in;
            r_sync <= r_meta;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic             r_level;
        logic             r_pulse;
        state_t           r_state;
        state_t           w_state_nxt;
        logic             w_pulse_nxt;
        logic             w_differ;
        logic             w_accept;
        logic             w_acc_press;
        logic             w_acc_release;

        // Sync is active-low and r_level active-high, so equal values mean disagreement.
        assign w_differ      = (r_sync[g] == r_level);
        assign w_accept      = w_differ && (r_cnt == DB_LAST);
        assign w_acc_press   = w_accept && !r_level;
        assign w_acc_release = w_accept &&  r_level;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else begin
                if (!w_differ || w_accept) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_accept) begin
                    r_level <= ~r_level;
                end
            end
        end

`ifdef BTN_REPEAT_EN
        localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_CYC - 1);
        localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(RPT_CYC - 1);

        logic [RPT_W-1:0] r_rpt_cnt;
        logic             r_rpt_phase;
        logic             w_fire;

        // r_rpt_cnt equals cycles since the first pulse (hold phase) or since the last repeat.
        assign w_fire = (r_state != S_IDLE) && !w_acc_release &&
                        (r_rpt_phase ? (r_rpt_cnt == RPT_LAST) : (r_rpt_cnt == HOLD_LAST));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_rpt_cnt   <= '0;
                r_rpt_phase <= 1'b0;
            end else if (r_state == S_IDLE || w_acc_release) begin
                r_rpt_cnt   <= '0;
                r_rpt_phase <= 1'b0;
            end else if (w_fire) begin
                r_rpt_cnt   <= '0;
                r_rpt_phase <= 1'b1;
            end else begin
                r_rpt_cnt   <= r_rpt_cnt + RPT_W'(1);
            end
        end
`endif

        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        always_comb begin
            w_state_nxt = r_state;
            w_pulse_nxt = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_acc_press) begin
                        w_state_nxt = S_PULSE;
                        w_pulse_nxt = 1'b1;
                    end
                end
                S_PULSE: w_state_nxt = w_acc_release ? S_IDLE : S_HELD;
                S_HELD: begin
                    if (w_acc_release) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
`ifdef BTN_REPEAT_EN
            if (w_fire) begin
                w_pulse_nxt = 1'b1;
            end
`endif
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= S_IDLE;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_pulse <= w_pulse_nxt;
            end
        end

        assign b_pulse[g] = r_pulse;
        assign b_level[g] = r_level;
    end

    assign b_any = |b_pulse;

endmodule
